ascon_perm_engine: RTL and testbench

Self-sequenced ASCON permutation engine. It accepts a 320-bit state with a start handshake and runs either p^a (12 rounds) or p^b (NB_ROUNDS_B rounds) with its own round counter. It applies the begin/end key/data XORs and captures the cipher word and tag. UNROLL rounds are computed per clock, so the ASCON-128/128a top FSM only issues start and waits for done instead of stepping rounds itself.

---
 rtl/ascon_pack.sv | 25 ++
 rtl/ascon_round.sv | 39 +++
 rtl/ascon_perm_engine.sv | 134 +++++++++++++
 tb/tb_ascon_perm_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and helpers for the ASCON permutation engine.
package ascon_pack;

    typedef struct packed {
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] s3;
        logic [63:0] s4;
    } type_state;

    localparam int NB_ROUNDS_A = 12;

    typedef enum logic {IDLE, RUN} type_perm_fsm;

    // c_r = 0xF0 - r*0x0F, i.e. F0, E1, D2, ... 4B for r = 0..11
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return 8'hF0 - ({4'd0, r} * 8'h0F);
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  logic [3:0] rnd,
    input  type_state  din,
    output type_state  dout
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    // constant addition folded into the S-box input XORs
    assign a0 = din.s0 ^ din.s4;
    assign a1 = din.s1;
    assign a2 = din.s2 ^ {56'd0, round_const(rnd)} ^ din.s1;
    assign a3 = din.s3;
    assign a4 = din.s4 ^ din.s3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    assign dout.s0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
    assign dout.s1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
    assign dout.s2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
    assign dout.s3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
    assign dout.s4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequenced ASCON p^a / p^b engine, UNROLL rounds per clock.
// Optional abort input enabled by defining ASCON_PERM_ABORT_EN.
module ascon_perm_engine
    import ascon_pack::*;
#(
    parameter int UNROLL      = 1,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  type_state    state_i,
    input  logic [63:0]  data_i,
    input  logic [127:0] key_i,
    input  logic         en_xor_data_b_i,
    input  logic         en_xor_key_b_i,
    input  logic         en_xor_key_e_i,
    input  logic         en_xor_lsb_e_i,
    input  logic         en_cipher_i,
    input  logic         en_tag_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         ready_o,
    output logic         done_o,
    output type_state    state_o,
    output logic [63:0]  cipher_o,
    output logic [127:0] tag_o
);

    if (!(UNROLL == 1 || UNROLL == 2) || (NB_ROUNDS_A % UNROLL) != 0 ||
        (NB_ROUNDS_B % UNROLL) != 0 || NB_ROUNDS_B > NB_ROUNDS_A) begin : g_bad_cfg
        $error("ascon_perm_engine: illegal UNROLL/NB_ROUNDS_B combination");
    end

    type_perm_fsm      fsm_q, fsm_d;
    logic [3:0]        rnd_q;
    logic              key_e_q, lsb_e_q, tag_q;
    logic              accept, finish, kill, last;
    type_state         beg, fin;
    type_state [UNROLL:0] chain;

    assign chain[0] = state_o;
    for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
        ascon_round u_round (
            .rnd  (rnd_q + 4'(u)),
            .din  (chain[u]),
            .dout (chain[u+1])
        );
    end

    always_comb begin
        beg = state_i;
        if (en_xor_data_b_i) beg.s0 = beg.s0 ^ data_i;
        if (en_xor_key_b_i)  {beg.s1, beg.s2} = {beg.s1, beg.s2} ^ key_i;
    end

    // end-XOR uses the live key; the top holds it stable across the message
    always_comb begin
        fin = chain[UNROLL];
        if (key_e_q) {fin.s3, fin.s4} = {fin.s3, fin.s4} ^ key_i;
        if (lsb_e_q) fin.s4 = fin.s4 ^ 64'h1;
    end

    assign last    = ({1'b0, rnd_q} + 5'(UNROLL)) == 5'(NB_ROUNDS_A);
    assign ready_o = (fsm_q == IDLE);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) fsm_q <= IDLE;
        else           fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d  = fsm_q;
        accept = 1'b0;
        finish = 1'b0;
        kill   = 1'b0;
        case (fsm_q)
            IDLE: if (start_i) begin
                fsm_d  = RUN;
                accept = 1'b1;
            end
            RUN: if (last) begin
                fsm_d  = IDLE;
                finish = 1'b1;
            end
            default: fsm_d = IDLE;
        endcase
`ifdef ASCON_PERM_ABORT_EN
        // abort beats a coinciding last round
        if (fsm_q == RUN && abort_i) begin
            fsm_d  = IDLE;
            finish = 1'b0;
            kill   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_o  <= '0;
            cipher_o <= '0;
            tag_o    <= '0;
            done_o   <= 1'b0;
            rnd_q    <= '0;
            key_e_q  <= 1'b0;
            lsb_e_q  <= 1'b0;
            tag_q    <= 1'b0;
        end else begin
            done_o <= finish;
            if (accept) begin
                state_o <= beg;
                if (en_cipher_i) cipher_o <= beg.s0;
                key_e_q <= en_xor_key_e_i;
                lsb_e_q <= en_xor_lsb_e_i;
                tag_q   <= en_tag_i;
                rnd_q   <= mode_i ? 4'(NB_ROUNDS_A - NB_ROUNDS_B) : 4'd0;
            end else if (kill) begin
                state_o <= '0;
                tag_o   <= '0;
                rnd_q   <= '0;
            end else if (finish) begin
                state_o <= fin;
                if (tag_q) tag_o <= {chain[UNROLL].s3, chain[UNROLL].s4};
                rnd_q   <= '0;
            end else if (fsm_q == RUN) begin
                state_o <= chain[UNROLL];
                rnd_q   <= rnd_q + 4'(UNROLL);
            end
        end
    end

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Table-driven scoreboard bench for ascon_perm_engine over three configurations.
module tb_ascon_perm_engine;
    import ascon_pack::*;

    localparam int CFG_U [3] = '{1, 2, 2};
    localparam int CFG_B [3] = '{6, 6, 8};
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    typedef struct {
        int           sel;
        logic         mode;
        type_state    st;
        logic [63:0]  data;
        logic [127:0] key;
        logic [5:0]   fl;      // {xor_data_b, xor_key_b, xor_key_e, xor_lsb_e, cipher, tag}
        logic         wig;
        type_state    exp_st;
        logic [63:0]  exp_ci;
        logic [127:0] exp_tag;
        int           exp_lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start [3];
    logic         mode;
    type_state    st_in;
    logic [63:0]  data;
    logic [127:0] key;
    logic         xd, xkb, xke, xl, ec, et;
`ifdef ASCON_PERM_ABORT_EN
    logic         abort;
`endif
    logic         rdy [3];
    logic         dn [3];
    type_state    st_out [3];
    logic [63:0]  ci [3];
    logic [127:0] tg [3];

    int n_vec = 0;
    int n_err = 0;
    logic [63:0]  mci [3];
    logic [127:0] mtg [3];
    vec_t sb [$];
    vec_t tbl [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ascon_perm_engine #(.UNROLL(CFG_U[g]), .NB_ROUNDS_B(CFG_B[g])) u_dut (
            .clock_i         (clk),
            .resetb_i        (rst),
            .start_i         (start[g]),
            .mode_i          (mode),
            .state_i         (st_in),
            .data_i          (data),
            .key_i           (key),
            .en_xor_data_b_i (xd),
            .en_xor_key_b_i  (xkb),
            .en_xor_key_e_i  (xke),
            .en_xor_lsb_e_i  (xl),
            .en_cipher_i     (ec),
            .en_tag_i        (et),
`ifdef ASCON_PERM_ABORT_EN
            .abort_i         (abort),
`endif
            .ready_o         (rdy[g]),
            .done_o          (dn[g]),
            .state_o         (st_out[g]),
            .cipher_o        (ci[g]),
            .tag_o           (tg[g])
        );
    end

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v};
        return d[n +: 64];
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, o;
        type_state   q;
        x[0] = s.s0; x[1] = s.s1; x[2] = s.s2; x[3] = s.s3; x[4] = s.s4;
        x[2][7:0] = x[2][7:0] ^ 8'(240 - 15 * r);
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX[col];
            for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
        end
        q.s0 = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
        q.s1 = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
        q.s2 = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
        q.s3 = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
        q.s4 = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
        return q;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic type_state rstate();
        type_state s;
        s.s0 = r64(); s.s1 = r64(); s.s2 = r64(); s.s3 = r64(); s.s4 = r64();
        return s;
    endfunction

    // builds a vector and its expected result, tracking held cipher/tag per instance
    function automatic vec_t mk(input int sel, input logic md, input type_state st,
                                input logic [63:0] dt, input logic [127:0] k,
                                input logic [5:0] fl, input logic wig);
        vec_t v;
        type_state s;
        int r0;
        v.sel = sel; v.mode = md; v.st = st; v.data = dt; v.key = k; v.fl = fl; v.wig = wig;
        s = st;
        if (fl[5]) s.s0 = s.s0 ^ dt;
        if (fl[4]) begin s.s1 = s.s1 ^ k[127:64]; s.s2 = s.s2 ^ k[63:0]; end
        if (fl[1]) mci[sel] = s.s0;
        r0 = md ? 12 - CFG_B[sel] : 0;
        for (int r = r0; r < 12; r++) s = model_round(s, r);
        if (fl[0]) mtg[sel] = {s.s3, s.s4};
        if (fl[3]) begin s.s3 = s.s3 ^ k[127:64]; s.s4 = s.s4 ^ k[63:0]; end
        if (fl[2]) s.s4 = s.s4 ^ 64'h1;
        v.exp_st = s; v.exp_ci = mci[sel]; v.exp_tag = mtg[sel];
        v.exp_lat = (12 - r0) / CFG_U[sel];
        return v;
    endfunction

    task automatic drive(input vec_t v);
        mode = v.mode; st_in = v.st; data = v.data; key = v.key;
        {xd, xkb, xke, xl, ec, et} = v.fl;
    endtask

    task automatic wait_done(input int sel, input logic wig, output int cyc);
        cyc = 0;
        while (!dn[sel] && cyc < 40) begin
            if (wig) begin
                start[sel] = ~start[sel];
                mode = ~mode;
                st_in = rstate();
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_done(input int sel, input int cyc);
        vec_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 320'(1), 320'(0));
            return;
        end
        e = sb.pop_front();
        chk("latency", 320'(cyc), 320'(e.exp_lat));
        chk("state", st_out[sel], e.exp_st);
        chk("tag", 320'(tg[sel]), 320'(e.exp_tag));
        chk("cipher_hold", 320'(ci[sel]), 320'(e.exp_ci));
        chk("ready_at_done", 320'(rdy[sel]), 320'(1));
    endtask

    task automatic apply(input vec_t v);
        int cyc;
        drive(v);
        start[v.sel] = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        start[v.sel] = 1'b0;
        chk("cipher_at_accept", 320'(ci[v.sel]), 320'(v.exp_ci));
        chk("busy_after_accept", 320'(rdy[v.sel]), 320'(0));
        wait_done(v.sel, v.wig, cyc);
        start[v.sel] = 1'b0;
        check_done(v.sel, cyc);
        @(posedge clk); #1;
        chk("done_one_cycle", 320'(dn[v.sel]), 320'(0));
        chk("state_hold", st_out[v.sel], v.exp_st);
    endtask

    initial begin
        vec_t a, b;
        int cyc, seen;
        type_state iv;

        for (int k = 0; k < 3; k++) begin start[k] = 1'b0; mci[k] = '0; mtg[k] = '0; end
        mode = 1'b0; st_in = '0; data = '0; key = '0;
        {xd, xkb, xke, xl, ec, et} = '0;
`ifdef ASCON_PERM_ABORT_EN
        abort = 1'b0;
`endif
        rst = 1'b1;

        iv = '0;
        iv.s0 = 64'h80400C0600000000;
        tbl[0] = mk(0, 1'b0, iv,       '0,                    '0,             6'b001000, 1'b0);
        tbl[1] = mk(1, 1'b1, rstate(), 64'h0123456789ABCDEF, '0,             6'b100010, 1'b0);
        tbl[2] = mk(2, 1'b1, rstate(), '0,                    {r64(), r64()}, 6'b001001, 1'b0);
        tbl[3] = mk(0, 1'b1, rstate(), r64(),                 {r64(), r64()}, 6'b111111, 1'b0);
        tbl[4] = mk(1, 1'b0, rstate(), '0,                    {r64(), r64()}, 6'b011100, 1'b0);
        tbl[5] = mk(2, 1'b0, rstate(), '0,                    '0,             6'b000001, 1'b0);
        tbl[6] = mk(0, 1'b0, rstate(), '0,                    {r64(), r64()}, 6'b001010, 1'b1);
        tbl[7] = mk(2, 1'b1, rstate(), r64(),                 '0,             6'b100110, 1'b1);

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", 320'(rdy[k]), 320'(1));
            chk("reset_done", 320'(dn[k]), 320'(0));
            chk("reset_state", st_out[k], '0);
            chk("reset_cipher", 320'(ci[k]), 320'(0));
            chk("reset_tag", 320'(tg[k]), 320'(0));
        end
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) apply(tbl[i]);

        // start held high: second accept lands on the done cycle of the first
        a = mk(1, 1'b1, rstate(), r64(), {r64(), r64()}, 6'b110011, 1'b0);
        b = mk(1, 1'b0, rstate(), '0,    {r64(), r64()}, 6'b001101, 1'b0);
        drive(a);
        start[1] = 1'b1;
        sb.push_back(a);
        @(posedge clk); #1;
        drive(b);
        sb.push_back(b);
        wait_done(1, 1'b0, cyc);
        check_done(1, cyc);
        @(posedge clk); #1;
        start[1] = 1'b0;
        chk("b2b_accept_busy", 320'(rdy[1]), 320'(0));
        chk("b2b_cipher", 320'(ci[1]), 320'(b.exp_ci));
        wait_done(1, 1'b0, cyc);
        check_done(1, cyc);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", st_out[1], b.exp_st);

`ifdef ASCON_PERM_ABORT_EN
        a = mk(0, 1'b0, rstate(), '0, '0, 6'b000001, 1'b0);
        drive(a);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ready", 320'(rdy[0]), 320'(1));
        chk("abort_state", st_out[0], '0);
        chk("abort_tag", 320'(tg[0]), 320'(0));
        mtg[0] = '0;
        seen = 0;
        repeat (14) begin
            if (dn[0]) seen++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 320'(seen), 320'(0));
`endif

        // asynchronous reset in the middle of a p^a run
        a = mk(0, 1'b0, rstate(), '0, {r64(), r64()}, 6'b001011, 1'b0);
        drive(a);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("midrun_reset_state", st_out[0], '0);
        chk("midrun_reset_ready", 320'(rdy[0]), 320'(1));
        chk("midrun_reset_cipher", 320'(ci[0]), 320'(0));
        chk("midrun_reset_tag", 320'(tg[0]), 320'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin mci[k] = '0; mtg[k] = '0; end
        seen = 0;
        repeat (15) begin
            if (dn[0]) seen++;
            @(posedge clk); #1;
        end
        chk("midrun_reset_no_done", 320'(seen), 320'(0));

        apply(mk(0, 1'b1, rstate(), r64(), '0, 6'b100010, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
